// File: rtl/alu_sched_if.sv
// alu_sched_if: request/response channels for both requesters plus the
// shared-ALU connection. slave = scheduler side, master = requesters/ALU side.
interface alu_sched_if #(
    parameter int WIDTH = 32
);
    logic             r0_req_valid;
    logic             r0_req_ready;
    logic [3:0]       r0_req_control;
    logic [WIDTH-1:0] r0_req_a;
    logic [WIDTH-1:0] r0_req_b;
    logic             r0_resp_valid;
    logic             r0_resp_ready;
    logic [WIDTH-1:0] r0_resp_result;
    logic             r0_resp_zero;
    logic             r0_resp_sign;

    logic             r1_req_valid;
    logic             r1_req_ready;
    logic [3:0]       r1_req_control;
    logic [WIDTH-1:0] r1_req_a;
    logic [WIDTH-1:0] r1_req_b;
    logic             r1_resp_valid;
    logic             r1_resp_ready;
    logic [WIDTH-1:0] r1_resp_result;
    logic             r1_resp_zero;
    logic             r1_resp_sign;

    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_sign;

    modport slave (
        input  r0_req_valid, r0_req_control, r0_req_a, r0_req_b, r0_resp_ready,
        output r0_req_ready, r0_resp_valid, r0_resp_result, r0_resp_zero, r0_resp_sign,
        input  r1_req_valid, r1_req_control, r1_req_a, r1_req_b, r1_resp_ready,
        output r1_req_ready, r1_resp_valid, r1_resp_result, r1_resp_zero, r1_resp_sign,
        output alu_control, alu_a, alu_b,
        input  alu_result, alu_zero, alu_sign
    );

    modport master (
        output r0_req_valid, r0_req_control, r0_req_a, r0_req_b, r0_resp_ready,
        input  r0_req_ready, r0_resp_valid, r0_resp_result, r0_resp_zero, r0_resp_sign,
        output r1_req_valid, r1_req_control, r1_req_a, r1_req_b, r1_resp_ready,
        input  r1_req_ready, r1_resp_valid, r1_resp_result, r1_resp_zero, r1_resp_sign,
        input  alu_control, alu_a, alu_b,
        output alu_result, alu_zero, alu_sign
    );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: two-requester scheduler sharing one combinational ALU.
// One operation in flight; response returns to the requester that issued it.
// Option: define ALU_SCHED_FIXED_PRIO_EN to make requester 0 always win
// contention (default is round-robin on last_grant).
//
// state | meaning
// IDLE  | arbitrate, accept one request, latch operands
// EXEC  | drive shared ALU from operand registers, capture result
// RESP  | hold response to owner until its resp_ready
module alu_sched #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_sched_if.slave bus,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic [3:0]       op_control_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] res_result_q;
    logic             res_zero_q;
    logic             res_sign_q;
    logic             prefer0;
    logic             grant0;
    logic             grant1;
    logic             owner_ready;

    // Contention tie-break: requester 0 wins when it did not win last time.
`ifdef ALU_SCHED_FIXED_PRIO_EN
    assign prefer0 = 1'b1;
`else
    assign prefer0 = last_grant_q;
`endif

    assign owner_ready = owner_q ? bus.r1_resp_ready : bus.r0_resp_ready;

    // Next-state and grant decode; grants only exist in IDLE.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = bus.r0_req_valid & (~bus.r1_req_valid | prefer0);
                grant1 = bus.r1_req_valid & ~grant0;
                if (grant0 | grant1) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on accept, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_control_q <= 4'd0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_result_q <= '0;
            res_zero_q   <= 1'b0;
            res_sign_q   <= 1'b0;
        end else begin
            if (grant0 | grant1) begin
                last_grant_q <= grant1;
                owner_q      <= grant1;
                op_control_q <= grant1 ? bus.r1_req_control : bus.r0_req_control;
                op_a_q       <= grant1 ? bus.r1_req_a : bus.r0_req_a;
                op_b_q       <= grant1 ? bus.r1_req_b : bus.r0_req_b;
            end
            if (state_q == EXEC) begin
                res_result_q <= bus.alu_result;
                res_zero_q   <= bus.alu_zero;
                res_sign_q   <= bus.alu_sign;
            end
        end
    end

    assign bus.r0_req_ready   = grant0;
    assign bus.r1_req_ready   = grant1;
    assign bus.r0_resp_valid  = (state_q == RESP) && !owner_q;
    assign bus.r1_resp_valid  = (state_q == RESP) && owner_q;
    assign bus.r0_resp_result = res_result_q;
    assign bus.r1_resp_result = res_result_q;
    assign bus.r0_resp_zero   = res_zero_q;
    assign bus.r1_resp_zero   = res_zero_q;
    assign bus.r0_resp_sign   = res_sign_q;
    assign bus.r1_resp_sign   = res_sign_q;
    assign bus.alu_control    = op_control_q;
    assign bus.alu_a          = op_a_q;
    assign bus.alu_b          = op_b_q;
    assign busy               = (state_q != IDLE);
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester round-robin scheduler that shares a single combinational `alu` instance between requesters in the RISC-V core, e.g. execute-stage integer ops and branch/address compare. It accepts one operation at a time through a valid/ready request channel and latches the operands. It drives the shared ALU for one cycle, registers `result`/`zero`/`sign`, and returns them on a valid/ready response channel to the requester that issued the operation.

## Interface

- `WIDTH`, 32, operand/result width; must match the shared `alu` instance.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low.
- `rN_req_valid`  in  1  requester N (N = 0, 1) has an operation pending.
- `rN_req_ready`  out  1  scheduler accepts requester N's operation this cycle.
- `rN_req_control`  in  4  ALU control code, passed through unchanged.
- `rN_req_a`, `rN_req_b`  in  WIDTH  signed operands.
- `rN_resp_valid`  out  1  result for requester N available.
- `rN_resp_ready`  in  1  requester N consumes the result.
- `rN_resp_result`  out  WIDTH  registered ALU result (shared bus, valid only with `rN_resp_valid`).
- `rN_resp_zero`, `rN_resp_sign`  out  1  registered ALU flags.
- `alu_control`  out  4  to shared ALU.
- `alu_a`, `alu_b`  out  WIDTH  to shared ALU.
- `alu_result`  in  WIDTH  from shared ALU.
- `alu_zero`, `alu_sign`  in  1  from shared ALU.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Arbitration is combinational. If exactly one `rN_req_valid` is high, that requester is granted. If both are high, the requester not equal to `last_grant` is granted.
  - `rN_req_ready` is high only for the granted requester, and only in IDLE.
  - On handshake (valid & ready), latch control, a and b into operand registers. Set `owner` to N and `last_grant` to N. Go to EXEC.
- **EXEC**
  - `alu_control`, `alu_a` and `alu_b` are driven from the operand registers.
  - At the end of the cycle, capture `alu_result`, `alu_zero` and `alu_sign` into the response registers. Go to RESP.
- **RESP**
  - `r<owner>_resp_valid` is held high, with result and flags stable, until `r<owner>_resp_ready` is high. Then go to IDLE.
  - The other requester's `resp_valid` stays low.
- The ALU inputs hold the last operand-register values outside EXEC and are don't-care there; the response must not depend on them.
- No `req_ready` is asserted outside IDLE. Requests arriving in EXEC or RESP wait.
- Reset values:
  - FSM = IDLE.
  - `last_grant` = 1, so requester 0 wins the first contention.
  - `owner` = 0.
  - Operand and response registers = 0.
  - All `*_ready`, `*_resp_valid` and `busy` = 0.
  - `alu_*` outputs = 0.
- Reset asserted mid-operation (EXEC or RESP) drops the in-flight operation. No response is produced for it.
- The scheduler performs no arithmetic. Widths pass through unmodified and signedness is the ALU's concern.

## Timing

- Request accepted at edge T (handshake in cycle before T). EXEC occupies cycle T to T+1. `resp_valid` rises after edge T+1. Latency is 2 cycles from accept to response.
- Minimum issue interval is 3 cycles (IDLE → EXEC → RESP → IDLE), with `resp_ready` tied high.
- `resp_ready` low in RESP stalls indefinitely. Result and flags must not change while stalled.
- A requester holding `req_valid` during its own RESP is eligible again in the following IDLE cycle, subject to round-robin.
- The `req_ready` path is combinational from `req_valid` and state. All other outputs are registered.

## Configuration

- `ALU_SCHED_FIXED_PRIO_EN`
  - Defined: requester 0 always wins contention. `last_grant` is still updated but ignored by arbitration.
  - Undefined (default): round-robin as above.

## Test plan

- **Reset:** hold `reset`=0 mid-EXEC of an r0 op with a=5, b=3, then release → all outputs 0 and state IDLE; no `r0_resp_valid` ever rises for the dropped op.
- **Single op:** r0 issues control=4'h2, a=32'd7, b=32'd9 → `r0_req_ready`=1 in the issue cycle. `alu_a`=7 and `alu_b`=9 in EXEC. `r0_resp_valid` rises 2 cycles after accept, with result/zero/sign equal to the ALU outputs sampled in EXEC. `r1_resp_valid` stays 0.
- **Contention:** r0 and r1 both valid continuously with distinct operands → grants alternate r0, r1, r0, r1. Each response returns to the correct owner with its own operands' result.
- **Backpressure:** `r1_resp_ready` held low for 5 cycles → `r1_resp_valid`, result and flags stable for all 5 cycles. `busy`=1 and both `req_ready`=0 throughout. Return to IDLE the cycle after `r1_resp_ready`=1.
- **Fixed priority:** with `ALU_SCHED_FIXED_PRIO_EN` defined, both requesters continuously valid → r0 granted every issue slot; r1 is granted only once r0 deasserts `req_valid`.
- **Zero flag:** a = b = 32'hFFFF_FFFF with a subtract-type control → `resp_zero` equals the ALU's `zero` captured in EXEC and is held through RESP.
